// File: rtl/dff_mem_pkg.sv
// Shared constants for the flip-flop memory controller: opcodes, pin field
// positions, status bit positions and the status byte packing helper.
package dff_mem_pkg;

    // Command opcodes carried on ui_in[7:6]
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_LOAD  = 2'b11;

    // ui_in field positions
    localparam int UI_CMD_HI = 7;
    localparam int UI_CMD_LO = 6;
    localparam int UI_FIFO   = 5;
    localparam int UI_AUTO   = 4;
    localparam int UI_GO     = 3;

    // uo_out status bit positions
    localparam int ST_FULL  = 7;
    localparam int ST_EMPTY = 6;
    localparam int ST_RDV   = 5;
    localparam int ST_ERR   = 4;

    // Assemble the status byte presented on uo_out
    function automatic logic [7:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       rd_valid,
        input logic       err,
        input logic [3:0] view
    );
        logic [7:0] s;
        s          = 8'h00;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_RDV]   = rd_valid;
        s[ST_ERR]   = err;
        s[3:0]      = view;
        return s;
    endfunction

endpackage

// File: rtl/dff_mem_sync.sv
// Input synchroniser for {uio_in, ui_in} with a rising-edge detector on the
// GO bit. Command and data share one pipeline so they stay aligned.
module dff_mem_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int GO_BIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             go_rise
);

    logic go_q;

    generate
        if (STAGES == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_sync
            logic [WIDTH-1:0] pipe [STAGES];

            // Shift the raw pins through the synchroniser chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        pipe[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    pipe[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign dout = pipe[STAGES-1];
        end
    endgenerate

    // Remember the previous synchronised GO level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q <= 1'b0;
        end else begin
            go_q <= dout[GO_BIT];
        end
    end

    assign go_rise = dout[GO_BIT] & ~go_q;

endmodule

// File: rtl/tt_um_dff_mem_ctrl.sv
// Flip-flop memory controller on the TinyTapeout pin set. One storage array
// serves as an auto-incrementing RAM or as a circular FIFO; one operation
// commits per synchronised GO rising edge and sticky status shows on uo_out.
module tt_um_dff_mem_ctrl
    import dff_mem_pkg::*;
#(
    parameter int RAM_BYTES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam int ADDR_BITS = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
    localparam logic [ADDR_BITS:0]   DEPTH   = (ADDR_BITS+1)'(RAM_BYTES);
    localparam logic [ADDR_BITS-1:0] A_ONE   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A_ZERO  = ADDR_BITS'(0);
    localparam logic [ADDR_BITS:0]   C_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0]   C_ZERO  = (ADDR_BITS+1)'(0);

    // Synchronised view of the pins
    logic [15:0] sync_word;
    logic        go_rise;
    logic [1:0]  cmd_s;
    logic        fifo_s;
    logic        auto_s;
    logic [7:0]  data_s;
    logic        unused_bits;

    dff_mem_sync #(
        .WIDTH  (16),
        .STAGES (SYNC_STAGES),
        .GO_BIT (UI_GO)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     ({uio_in, ui_in}),
        .dout    (sync_word),
        .go_rise (go_rise)
    );

    assign cmd_s       = sync_word[UI_CMD_HI:UI_CMD_LO];
    assign fifo_s      = sync_word[UI_FIFO];
    assign auto_s      = sync_word[UI_AUTO];
    assign data_s      = sync_word[15:8];
    assign unused_bits = ^sync_word[2:0];

    // Storage (never reset) and controller state
    logic [7:0]           mem [RAM_BYTES];
    logic [ADDR_BITS-1:0] addr_r, wr_ptr_r, rd_ptr_r;
    logic [ADDR_BITS:0]   count_r;
    logic                 mode_r;
    logic                 rd_valid_r;
    logic                 err_r;
    logic [7:0]           rdata_r;
    logic [7:0]           oe_r;
    logic [7:0]           status_r;

    // Next-state values
    logic [ADDR_BITS-1:0] addr_n, wr_ptr_n, rd_ptr_n;
    logic [ADDR_BITS:0]   count_n;
    logic                 mode_n;
    logic                 rd_valid_n;
    logic                 err_n;
    logic [7:0]           rdata_n;
    logic [7:0]           oe_n;
    logic [7:0]           status_n;
    logic                 we_s;
    logic [ADDR_BITS-1:0] waddr_s;
    logic                 mode_change_s;
    logic                 fire_s;

    assign mode_change_s = ena & (fifo_s != mode_r);
    assign fire_s        = ena & go_rise & ~mode_change_s;

    // Decide the effect of a mode change or a fired command
    always_comb begin
        addr_n     = addr_r;
        wr_ptr_n   = wr_ptr_r;
        rd_ptr_n   = rd_ptr_r;
        count_n    = count_r;
        mode_n     = mode_r;
        rd_valid_n = rd_valid_r;
        err_n      = err_r;
        rdata_n    = rdata_r;
        we_s       = 1'b0;
        waddr_s    = addr_r;

        if (mode_change_s) begin
            // Switching modes restarts the pointers but keeps memory contents
            mode_n     = fifo_s;
            addr_n     = A_ZERO;
            wr_ptr_n   = A_ZERO;
            rd_ptr_n   = A_ZERO;
            count_n    = C_ZERO;
            rd_valid_n = 1'b0;
            err_n      = 1'b0;
        end else if (fire_s) begin
            case (cmd_s)
                CMD_WRITE: begin
                    rd_valid_n = 1'b0;
                    if (!mode_r) begin
                        we_s    = 1'b1;
                        waddr_s = addr_r;
                        if (auto_s) begin
                            addr_n = addr_r + A_ONE;
                        end else begin
                            addr_n = addr_r;
                        end
                    end else if (count_r != DEPTH) begin
                        we_s     = 1'b1;
                        waddr_s  = wr_ptr_r;
                        wr_ptr_n = wr_ptr_r + A_ONE;
                        count_n  = count_r + C_ONE;
                    end else begin
                        // Overflow: drop the byte and flag it
                        err_n = 1'b1;
                    end
                end
                CMD_READ: begin
                    if (!mode_r) begin
                        rdata_n    = mem[addr_r];
                        rd_valid_n = 1'b1;
                        if (auto_s) begin
                            addr_n = addr_r + A_ONE;
                        end else begin
                            addr_n = addr_r;
                        end
                    end else if (count_r != C_ZERO) begin
                        rdata_n    = mem[rd_ptr_r];
                        rd_ptr_n   = rd_ptr_r + A_ONE;
                        count_n    = count_r - C_ONE;
                        rd_valid_n = 1'b1;
                    end else begin
                        // Underflow: keep the last read data, flag it
                        rd_valid_n = 1'b0;
                        err_n      = 1'b1;
                    end
                end
                CMD_LOAD: begin
                    rd_valid_n = 1'b0;
                    err_n      = 1'b0;
                    if (!mode_r) begin
                        addr_n = data_s[ADDR_BITS-1:0];
                    end else begin
                        wr_ptr_n = A_ZERO;
                        rd_ptr_n = A_ZERO;
                        count_n  = C_ZERO;
                    end
                end
                default: begin
                    rd_valid_n = rd_valid_r;
                end
            endcase
        end else begin
            mode_n = mode_r;
        end
    end

    // Decode output enable and status from the next register values
    always_comb begin
        oe_n     = (cmd_s == CMD_READ) ? 8'hFF : 8'h00;
        status_n = pack_status(
            mode_n & (count_n == DEPTH),
            (count_n == C_ZERO),
            rd_valid_n,
            err_n,
            mode_n ? 4'(count_n) : 4'(addr_n)
        );
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= A_ZERO;
            wr_ptr_r   <= A_ZERO;
            rd_ptr_r   <= A_ZERO;
            count_r    <= C_ZERO;
            mode_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= 8'h00;
            oe_r       <= 8'h00;
            status_r   <= 8'h40;
        end else begin
            addr_r     <= addr_n;
            wr_ptr_r   <= wr_ptr_n;
            rd_ptr_r   <= rd_ptr_n;
            count_r    <= count_n;
            mode_r     <= mode_n;
            rd_valid_r <= rd_valid_n;
            err_r      <= err_n;
            rdata_r    <= rdata_n;
            oe_r       <= oe_n;
            status_r   <= status_n;
        end
    end

    // Storage array write port; whole-byte writes only
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= data_s;
        end
    end

    assign uio_out = rdata_r;
    assign uio_oe  = oe_r;
    assign uo_out  = status_r;

endmodule

// File: tb/tb_tt_um_dff_mem_ctrl.sv
// Directed self-checking bench for tt_um_dff_mem_ctrl (RAM_BYTES=16,
// SYNC_STAGES=2). Expected read data goes into a scoreboard queue when a
// READ is issued and is popped when the result is checked.
module tb_tt_um_dff_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int tests = 0;
    int fails = 0;
    logic cur_fifo = 1'b0;
    logic cur_auto = 1'b1;
    logic [7:0] sb [$];

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] WRITE = 2'b01;
    localparam logic [1:0] READ  = 2'b10;
    localparam logic [1:0] LOAD  = 2'b11;

    tt_um_dff_mem_ctrl #(
        .RAM_BYTES   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Compare uio_out against the oldest scoreboard entry
    task automatic sb_check(input string tag);
        logic [7:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        check(tag, uio_out, exp);
    endtask

    // One full GO pulse; cmd stays driven after go drops
    task automatic op(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clk);
        ui_in  = {cmd, cur_fifo, cur_auto, 1'b1, 3'b000};
        uio_in = data;
        repeat (5) @(negedge clk);
        ui_in[3] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic set_mode(input logic fifo);
        cur_fifo = fifo;
        @(negedge clk);
        ui_in = {NOP, cur_fifo, cur_auto, 1'b0, 3'b000};
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_uo_out", uo_out, 8'h40);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: RAM write/read with auto-increment
        op(LOAD, 8'h00);
        op(WRITE, 8'hA5);
        op(WRITE, 8'h3C);
        op(LOAD, 8'h00);
        sb.push_back(8'hA5);
        op(READ, 8'h00);
        sb_check("ram_read0");
        check("ram_oe_read", uio_oe, 8'hFF);
        sb.push_back(8'h3C);
        op(READ, 8'h00);
        sb_check("ram_read1");
        check("ram_status_after_reads", uo_out, 8'h62);

        // 2: address wrap at the top of the array
        op(LOAD, 8'h0F);
        op(WRITE, 8'h11);
        check("ram_wrap_status", uo_out, 8'h40);
        check("ram_oe_write", uio_oe, 8'h00);
        op(LOAD, 8'h0F);
        sb.push_back(8'h11);
        op(READ, 8'h00);
        sb_check("ram_read15");
        check("ram_read15_status", uo_out, 8'h60);

        // 3: FIFO fill, overflow, drain
        set_mode(1'b1);
        check("fifo_mode_entry", uo_out, 8'h40);
        for (int i = 0; i < 16; i++) begin
            op(WRITE, 8'(i));
            sb.push_back(8'(i));
        end
        check("fifo_full", uo_out, 8'h80);
        op(WRITE, 8'hFF);
        check("fifo_overflow", uo_out, 8'h90);
        for (int i = 0; i < 16; i++) begin
            op(READ, 8'h00);
            sb_check("fifo_pop");
            check("fifo_count", {4'h0, uo_out[3:0]}, 8'(15 - i));
        end
        check("fifo_drained", uo_out, 8'h70);

        // 4: underflow then flush
        op(READ, 8'h00);
        check("fifo_underflow_status", uo_out, 8'h50);
        check("fifo_underflow_data", uio_out, 8'h0F);
        op(LOAD, 8'h00);
        check("fifo_flush", uo_out, 8'h40);

        // 5: held GO fires once; GO ignored while disabled
        @(negedge clk);
        ui_in  = {WRITE, cur_fifo, cur_auto, 1'b1, 3'b000};
        uio_in = 8'h77;
        repeat (10) @(negedge clk);
        ui_in[3] = 1'b0;
        repeat (5) @(negedge clk);
        check("held_go_one_push", uo_out, 8'h01);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ui_in[3] = 1'b1;
            repeat (4) @(negedge clk);
            ui_in[3] = 1'b0;
            repeat (4) @(negedge clk);
        end
        ena = 1'b1;
        repeat (5) @(negedge clk);
        check("ena_low_no_change", uo_out, 8'h01);
        sb.push_back(8'h77);
        op(READ, 8'h00);
        sb_check("held_go_readback");
        check("held_go_empty", uo_out, 8'h60);

        // 6: mode change clears pointers, keeps data; async reset mid-op
        for (int i = 0; i < 5; i++) begin
            op(WRITE, 8'h50 + 8'(i));
        end
        check("fifo_count5", uo_out, 8'h05);
        set_mode(1'b0);
        check("mode_change_clear", uo_out, 8'h40);
        op(LOAD, 8'h01);
        sb.push_back(8'h50);
        op(READ, 8'h00);
        sb_check("data_kept");
        check("data_kept_status", uo_out, 8'h62);
        @(negedge clk);
        ui_in = {READ, cur_fifo, cur_auto, 1'b1, 3'b000};
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h00;
        #1;
        check("async_reset_uo_out", uo_out, 8'h40);
        check("async_reset_uio_out", uio_out, 8'h00);
        check("async_reset_uio_oe", uio_oe, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_uo_out", uo_out, 8'h40);
        check("post_reset_uio_out", uio_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
